hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core; companion to the forwarding logic.
- Detects load-use hazards, squashes wrong-path instructions on taken branches, and freezes the whole pipeline while data memory has not answered.
- Bounds each memory wait with a timeout that traps into a sticky error state.
- Counts stall cycles for performance monitoring.

Parameters:
REG_DIR_WIDTH, 3, register address width.
WAIT_CNT_WIDTH, 4, memory-wait counter width.
MEM_TIMEOUT, 12, maximum wait count before error; must be less than 2^WAIT_CNT_WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
IFIDRegisterRs  in  REG_DIR_WIDTH  Rs of instruction in ID.
IFIDRegisterRt  in  REG_DIR_WIDTH  Rt of instruction in ID.
IFIDUsesRt  in  1  ID instruction reads Rt as a source.
IDEXRegisterRt  in  REG_DIR_WIDTH  destination of instruction in EX.
IDEXMemRead  in  1  EX instruction is a load.
EXBranchTaken  in  1  branch resolved taken in EX.
EXMEMMemRead  in  1  MEM-stage load.
EXMEMMemWrite  in  1  MEM-stage store.
mem_ready  in  1  data memory completes access this cycle.
PCWrite  out  1  PC update enable.
IFIDWrite  out  1  IF/ID register enable.
IDEXWrite  out  1  ID/EX register enable.
EXMEMWrite  out  1  EX/MEM register enable.
IFIDFlush  out  1  zero IF/ID contents.
IDEXFlush  out  1  load bubble (zero control) into ID/EX.
MEMWBBubble  out  1  load bubble into MEM/WB.
mem_req  out  1  data memory request.
mem_timeout  out  1  sticky timeout flag.
stall_cycles  out  16  saturating stall counter.

Behaviour:
Registered FSM states: INIT, RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs; counters are registered.

Reset (rst_n=0, asynchronous, any state, including mid-wait):
- State goes to INIT; wait_cnt=0, stall_cycles=0, mem_timeout=0.

INIT (one cycle after reset release):
- All *Write=0; IFIDFlush=IDEXFlush=MEMWBBubble=1; mem_req=0.
- Next state RUN.

RUN and the MEM_WAIT release cycle, evaluated in priority order:
1. mem_busy = (EXMEMMemRead|EXMEMMemWrite) & !mem_ready, RUN only.
   - Outputs: all *Write=0, MEMWBBubble=1, flushes=0.
   - Next state MEM_WAIT; wait_cnt<=1.
2. EXBranchTaken:
   - Outputs: PCWrite=1 (loads target), IFIDFlush=1, IDEXFlush=1, other writes=1.
   - Branch overrides load-use.
3. Load-use, defined as IDEXMemRead & IDEXRegisterRt!=0 & (IDEXRegisterRt==IFIDRegisterRs | (IFIDUsesRt & IDEXRegisterRt==IFIDRegisterRt)):
   - Outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IDEXWrite=1, EXMEMWrite=1.
   - Lasts exactly one cycle; the bubble removes the condition.
4. Otherwise:
   - All *Write=1; flushes/bubbles=0.

MEM_WAIT:
- mem_req=1.
- mem_ready=0: full freeze (as in rule 1). If wait_cnt==MEM_TIMEOUT, next state ERROR; else wait_cnt+1.
- mem_ready=1 (release cycle): pipeline advances this cycle; rules 2-4 apply; next state RUN; wait_cnt<=0.
- EXBranchTaken during freeze: ignored. EX is held, so the branch is acted on in the release cycle.
- Timing: with MEM_TIMEOUT=12, 13 frozen cycles occur, then ERROR on the 14th.

ERROR:
- All *Write=0, IFIDFlush=IDEXFlush=MEMWBBubble=1, mem_req=0, mem_timeout=1.
- Exit only via reset.

mem_req:
- In RUN: EXMEMMemRead|EXMEMMemWrite.
- In MEM_WAIT: 1.
- Otherwise: 0.

stall_cycles:
- +1 on every RUN/MEM_WAIT cycle with PCWrite=0.
- Saturates at 16'hFFFF; never wraps.
- Not counted in INIT or ERROR.

Test Plan:
1. Reset then release rst_n:
   - During reset and the INIT cycle: all writes 0, flushes 1, stall_cycles=0.
   - Next cycle RUN with no hazards: PCWrite=IFIDWrite=1.
2. Load-use with IDEXMemRead=1, IDEXRegisterRt=3:
   - IFIDRegisterRs=3: one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; stall_cycles 0->1.
   - Repeat with IDEXRegisterRt=0: no stall.
   - Repeat with Rt match but IFIDUsesRt=0: no stall.
3. EXBranchTaken=1 together with a load-use match:
   - IFIDFlush=IDEXFlush=1, PCWrite=1; stall_cycles unchanged.
4. EXMEMMemRead=1 with mem_ready low for 3 cycles, then high:
   - Outputs: 3 frozen cycles (all *Write=0, MEMWBBubble=1), mem_req=1 throughout, release on the 4th cycle.
   - stall_cycles +3.
5. EXMEMMemWrite=1 with mem_ready never asserted:
   - 13 frozen cycles, then ERROR: mem_timeout=1 and mem_req=0, held for 20 further cycles.
   - Pulsing rst_n clears mem_timeout.
6. Assert rst_n=0 in the 2nd MEM_WAIT cycle, without a clock edge:
   - Outputs take reset values immediately; after release, sequence is INIT then RUN.
7. Force 65540 load-use stalls:
   - stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard/stall control bundle between pipeline datapath and sequencing controller
interface hazard_stall_ctrl_if #(parameter int REG_DIR_WIDTH = 3);
  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRs;
  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRt;
  logic [REG_DIR_WIDTH-1:0] IDEXRegisterRt;
  logic IFIDUsesRt;
  logic IDEXMemRead;
  logic EXBranchTaken;
  logic EXMEMMemRead;
  logic EXMEMMemWrite;
  logic mem_ready;
  logic PCWrite;
  logic IFIDWrite;
  logic IDEXWrite;
  logic EXMEMWrite;
  logic IFIDFlush;
  logic IDEXFlush;
  logic MEMWBBubble;
  logic mem_req;
  logic mem_timeout;
  logic [15:0] stall_cycles;
  modport master (
    output IFIDRegisterRs, IFIDRegisterRt, IDEXRegisterRt, IFIDUsesRt, IDEXMemRead,
           EXBranchTaken, EXMEMMemRead, EXMEMMemWrite, mem_ready,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush,
           MEMWBBubble, mem_req, mem_timeout, stall_cycles
  );
  modport slave (
    input  IFIDRegisterRs, IFIDRegisterRt, IDEXRegisterRt, IFIDUsesRt, IDEXMemRead,
           EXBranchTaken, EXMEMMemRead, EXMEMMemWrite, mem_ready,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush,
           MEMWBBubble, mem_req, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stalls, branch squash, memory-wait freeze with timeout trap, stall counter
module hazard_stall_ctrl #(
  parameter int REG_DIR_WIDTH  = 3,
  parameter int WAIT_CNT_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 12
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;
  state_t r_state, w_next;
  logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt, w_wait_cnt;
  logic [15:0] r_stall;
  logic w_mem_acc, w_load_use, w_busy, w_freeze;
  // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble}
  logic [6:0] w_ctl;
  always_comb begin
    w_mem_acc  = bus.EXMEMMemRead | bus.EXMEMMemWrite;
    w_load_use = bus.IDEXMemRead && bus.IDEXRegisterRt != REG_DIR_WIDTH'(0) &&
                 (bus.IDEXRegisterRt == bus.IFIDRegisterRs ||
                  (bus.IFIDUsesRt && bus.IDEXRegisterRt == bus.IFIDRegisterRt));
    w_busy     = r_state == RUN && w_mem_acc && !bus.mem_ready;
    w_freeze   = w_busy || (r_state == MEM_WAIT && !bus.mem_ready);
    w_ctl      = 7'b1111_000;
    if (r_state == INIT || r_state == ERROR) w_ctl = 7'b0000_111;
    else if (w_freeze) w_ctl = 7'b0000_001;
    else if (bus.EXBranchTaken) w_ctl = 7'b1111_110;
    else if (w_load_use) w_ctl = 7'b0011_010;
    w_next     = r_state;
    w_wait_cnt = r_wait_cnt;
    case (r_state)
      INIT: w_next = RUN;
      RUN: if (w_busy) begin
        w_next     = MEM_WAIT;
        w_wait_cnt = WAIT_CNT_WIDTH'(1);
      end
      MEM_WAIT: if (bus.mem_ready) begin
        w_next     = RUN;
        w_wait_cnt = '0;
      end else if (r_wait_cnt == WAIT_CNT_WIDTH'(MEM_TIMEOUT)) w_next = ERROR;
      else w_wait_cnt = r_wait_cnt + WAIT_CNT_WIDTH'(1);
      default: w_next = ERROR;
    endcase
  end
  assign {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
          bus.IFIDFlush, bus.IDEXFlush, bus.MEMWBBubble} = w_ctl;
  assign bus.mem_req      = r_state == RUN ? w_mem_acc : r_state == MEM_WAIT;
  assign bus.mem_timeout  = r_state == ERROR;
  assign bus.stall_cycles = r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_wait_cnt <= '0;
      r_stall    <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt;
      if ((r_state == RUN || r_state == MEM_WAIT) && !w_ctl[6] && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table-driven RUN-state vectors plus hand sequences for wait, timeout, reset and saturation
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_stall;
  always #5 clk = ~clk;
  hazard_stall_ctrl_if #(.REG_DIR_WIDTH(3)) bus ();
  hazard_stall_ctrl #(.REG_DIR_WIDTH(3), .WAIT_CNT_WIDTH(4), .MEM_TIMEOUT(12)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {
    logic [2:0] rs, rt, ex_rt;
    logic       uses, ex_mr, br, mr, mw, rdy;
    logic [7:0] exp; // {pcw, ifidw, idexw, exmemw, ifidf, idexf, bub, req}
  } vec_t;
  vec_t tbl[10];
  localparam logic [7:0] O_IDLE = 8'b1111_0000;
  localparam logic [7:0] O_LU   = 8'b0011_0100;
  localparam logic [7:0] O_BR   = 8'b1111_1100;
  localparam logic [7:0] O_HALT = 8'b0000_1110;
  localparam logic [7:0] O_FRZ  = 8'b0000_0011;
  task automatic drive(input logic [2:0] rs, rt, ex_rt, input logic uses, ex_mr, br, mr, mw, rdy);
    bus.IFIDRegisterRs = rs; bus.IFIDRegisterRt = rt; bus.IDEXRegisterRt = ex_rt;
    bus.IFIDUsesRt = uses; bus.IDEXMemRead = ex_mr; bus.EXBranchTaken = br;
    bus.EXMEMMemRead = mr; bus.EXMEMMemWrite = mw; bus.mem_ready = rdy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_outs(input string name, input logic [7:0] exp);
    chk(name, {8'h00, bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
               bus.IFIDFlush, bus.IDEXFlush, bus.MEMWBBubble, bus.mem_req}, {8'h00, exp});
  endtask
  task automatic do_reset();
    #1 rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_outs("reset_outs", O_HALT);
    chk("reset_stall", bus.stall_cycles, 16'd0);
    chk("reset_timeout", {15'd0, bus.mem_timeout}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs("init_outs", O_HALT);
    tick();
    chk_outs("run_idle", O_IDLE);
    exp_stall = 16'd0;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{rs:0, rt:0, ex_rt:0, uses:0, ex_mr:0, br:0, mr:0, mw:0, rdy:0, exp:O_IDLE};
    tbl[1] = '{rs:3, rt:1, ex_rt:3, uses:1, ex_mr:1, br:0, mr:0, mw:0, rdy:0, exp:O_LU};
    tbl[2] = '{rs:0, rt:0, ex_rt:0, uses:1, ex_mr:1, br:0, mr:0, mw:0, rdy:0, exp:O_IDLE};
    tbl[3] = '{rs:1, rt:3, ex_rt:3, uses:0, ex_mr:1, br:0, mr:0, mw:0, rdy:0, exp:O_IDLE};
    tbl[4] = '{rs:1, rt:3, ex_rt:3, uses:1, ex_mr:1, br:0, mr:0, mw:0, rdy:0, exp:O_LU};
    tbl[5] = '{rs:3, rt:3, ex_rt:3, uses:1, ex_mr:0, br:0, mr:0, mw:0, rdy:0, exp:O_IDLE};
    tbl[6] = '{rs:3, rt:1, ex_rt:3, uses:1, ex_mr:1, br:1, mr:0, mw:0, rdy:0, exp:O_BR};
    tbl[7] = '{rs:2, rt:5, ex_rt:7, uses:1, ex_mr:0, br:1, mr:0, mw:0, rdy:0, exp:O_BR};
    tbl[8] = '{rs:2, rt:5, ex_rt:7, uses:1, ex_mr:1, br:0, mr:1, mw:0, rdy:1, exp:8'b1111_0001};
    tbl[9] = '{rs:6, rt:5, ex_rt:5, uses:1, ex_mr:1, br:0, mr:0, mw:1, rdy:1, exp:8'b0011_0101};
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].ex_rt, tbl[i].uses, tbl[i].ex_mr, tbl[i].br,
            tbl[i].mr, tbl[i].mw, tbl[i].rdy);
      #1;
      chk_outs($sformatf("vec%0d_outs", i), tbl[i].exp);
      tick();
      if (!tbl[i].exp[7]) exp_stall++;
      chk($sformatf("vec%0d_stall", i), bus.stall_cycles, exp_stall);
    end
    // load freezes for three cycles, branch during freeze is deferred to the release
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk_outs("wait_frz0", O_FRZ);
    tick();
    bus.EXBranchTaken = 1'b1;
    #1 chk_outs("wait_frz1_br", O_FRZ);
    tick();
    #1 chk_outs("wait_frz2_br", O_FRZ);
    tick();
    bus.mem_ready = 1'b1;
    #1 chk_outs("wait_release_br", 8'b1111_1101);
    tick();
    exp_stall += 16'd3;
    chk("wait_stall", bus.stall_cycles, exp_stall);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_outs("wait_back_run", O_IDLE);
    // store never answered: 13 frozen cycles then sticky error
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 13; c++) begin
      #1 chk_outs($sformatf("to_frz%0d", c), O_FRZ);
      tick();
    end
    exp_stall += 16'd13;
    for (int c = 0; c < 21; c++) begin
      chk_outs($sformatf("err_outs%0d", c), O_HALT);
      chk($sformatf("err_timeout%0d", c), {15'd0, bus.mem_timeout}, 16'd1);
      chk($sformatf("err_stall%0d", c), bus.stall_cycles, exp_stall);
      tick();
    end
    do_reset();
    chk("post_err_timeout", {15'd0, bus.mem_timeout}, 16'd0);
    // asynchronous reset in the second wait cycle
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    chk_outs("mid_wait", O_FRZ);
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst_outs", O_HALT);
    chk("async_rst_stall", bus.stall_cycles, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    #1 chk_outs("async_init", O_HALT);
    tick();
    chk_outs("async_run", O_IDLE);
    // saturation of the stall counter
    drive(3, 0, 3, 0, 1, 0, 0, 0, 0);
    exp_stall = 16'd0;
    for (int c = 0; c < 65534; c++) tick();
    chk("sat_fffe", bus.stall_cycles, 16'hFFFE);
    tick();
    chk("sat_ffff", bus.stall_cycles, 16'hFFFF);
    repeat (5) tick();
    chk("sat_hold", bus.stall_cycles, 16'hFFFF);
    chk_outs("sat_outs", O_LU);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
